lfsr9_checker: RTL and testbench
================================

// Module: lfsr9_checker
// PURPOSE
//  - Receive-side checker for the 9-bit XNOR LFSR stream (taps 4,8, Q[0] = newest bit).
//  - Self-synchronises to a serial bit stream, declares lock, then counts bit errors against the predicted sequence.
//  - Sits after the pattern source; used to validate note-pattern streams and link integrity in the game datapath.
// PARAMETERS
//  WIDTH     9   LFSR length; checker shift register width
//  TAP_A     4   first XNOR tap index
//  TAP_B     8   second XNOR tap index
//  LOCK_CNT  16  consecutive matches required to declare lock (1..255)
//  LOST_CNT  4   consecutive mismatches while locked that drop lock (1..15)
//  ERR_W     16  error counter width
// PORTS
//  Clock     in   1      rising-edge clock
//  Reset     in   1      asynchronous, active-low reset
//  Enable    in   1      Din valid this cycle; when low, all state holds
//  Din       in   1      received serial bit (generator Q[0] sequence)
//  ClrErr    in   1      synchronous clear of ErrCount
//  Locked    out  1      checker in LOCKED state
//  ErrPulse  out  1      one-cycle pulse: the previous valid bit mismatched while locked
//  ErrCount  out  ERR_W  saturating count of mismatches while locked
// BEHAVIOUR
//  - Reset (Reset=0): S=0, fill=0, run=0, miss=0, state=FILL, Locked=0, ErrPulse=0, ErrCount=0.
//  - Prediction: P = ~(S[TAP_A] ^ S[TAP_B]); S[0] = newest bit; shift is S <= {S[WIDTH-2:0], bit}.
//  - FILL: each valid bit shifts Din into S; after WIDTH bits -> HUNT (run=0).
//  - HUNT: Din==P and S!=all-ones -> run++; Din!=P -> run=0; S==all-ones -> run=0 (lock-up guard).
//    Always shift Din. When run reaches LOCK_CNT -> LOCKED; Locked=1 in the following cycle.
//  - LOCKED: shift P (not Din), so each channel error counts once.
//    Mismatch: ErrPulse=1 next cycle, ErrCount+1 (saturate at all-ones), miss++.
//    Match: miss=0. When miss reaches LOST_CNT -> FILL with fill=0, Locked=0.
//  - ErrPulse is registered and asserted only in the cycle after a mismatching valid bit; otherwise 0.
//  - Counter latency: ErrCount is updated in the same edge as ErrPulse.
//  - ClrErr and a mismatch in the same cycle: ErrCount <= 1. ClrErr alone: ErrCount <= 0.
//  - Enable=0: no shift, no counter or state change, ErrPulse=0.
//  - Reset asserted mid-stream: immediate return to reset values; no lock is retained.
// CONFIGURATION
//  - LFSR_CHK_BITCNT_EN defined: adds output BitCount [31:0].
//    - Counts valid bits checked while LOCKED; wraps modulo 2^32.
//    - Cleared by Reset and ClrErr; holds when Enable=0.
//  - LFSR_CHK_BITCNT_EN undefined: BitCount port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package lfsr_pkg:
//    - state enum {FILL, HUNT, LOCKED}
//    - LFSR_WIDTH=9, LFSR_TAP_A=4, LFSR_TAP_B=8
//    - lfsr_predict(S) function
//  - Sub-module lfsr9_step: combinational next-bit predictor, shared with the generator side.
//  - Top-level contents: FSM, shift register, run/miss/fill counters, error counter.
// TESTING
//  - Clean lock: drive generator output from zero state (bits 1,1,1,1,1,0,0,0,0,1,...).
//    Required: Locked=1 after exactly 9+16 valid bits; ErrCount=0 over 600 bits.
//  - Single error: flip bit 100 after lock.
//    Required: ErrPulse for one cycle, ErrCount=1, Locked stays 1.
//  - Burst loss: invert 4 consecutive bits after lock.
//    Required: ErrCount=4, Locked=0, then relock after 9+16 further clean bits.
//  - All-ones stream: hold Din=1 for 100 bits.
//    Required: Locked never asserts; ErrCount=0.
//  - Simultaneous events: ClrErr with a mismatch gives ErrCount=1.
//    Toggling Enable every other cycle gives the same lock point in valid bits.
//    Reset pulse mid-lock clears all outputs within the same cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and constants for the 9-bit XNOR LFSR generator/checker pair.
// The XNOR form uses taps 4 and 8; Q[0] holds the newest bit and all-ones is the lock-up state.
`timescale 1ns/1ps
package lfsr_pkg;

  typedef enum logic [1:0] {
    FILL,
    HUNT,
    LOCKED
  } state_t;

  localparam int LFSR_WIDTH = 9;
  localparam int LFSR_TAP_A = 4;
  localparam int LFSR_TAP_B = 8;

  // Next bit the generator will emit, given its current register contents.
  function automatic logic lfsr_predict(input logic [LFSR_WIDTH-1:0] s);
    return ~(s[LFSR_TAP_A] ^ s[LFSR_TAP_B]);
  endfunction

endpackage

// File: rtl/lfsr9_step.sv
// lfsr9_step: combinational next-bit predictor for the 9-bit XNOR LFSR.
// Kept as its own block so the generator and checker share one definition of the sequence.
`timescale 1ns/1ps
module lfsr9_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_WIDTH-1:0] state,
  output logic                  predict
);

  assign predict = lfsr_predict(state);

endmodule

// File: rtl/lfsr9_checker.sv
// lfsr9_checker: receive-side checker for the 9-bit XNOR LFSR stream.
// Fills its shift register from the line, hunts for a run of correct predictions,
// then flywheels on its own prediction while counting bit errors.
// Optional feature: define LFSR_CHK_BITCNT_EN to add the 32-bit BitCount output.
`timescale 1ns/1ps
module lfsr9_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOST_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Din,
  input  logic             ClrErr,
  output logic             Locked,
  output logic             ErrPulse,
`ifdef LFSR_CHK_BITCNT_EN
  output logic [31:0]      BitCount,
`endif
  output logic [ERR_W-1:0] ErrCount
);

  localparam logic [3:0] FILL_LAST = 4'(LFSR_WIDTH - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [3:0] LOST_LAST = 4'(LOST_CNT - 1);

  state_t                  state;
  logic [LFSR_WIDTH-1:0]   shift_reg;
  logic [3:0]              fill_cnt;
  logic [7:0]              run_cnt;
  logic [3:0]              miss_cnt;
  logic                    predict;
  logic                    all_ones;
  logic                    locked_miss;

  lfsr9_step u_step (
    .state   (shift_reg),
    .predict (predict)
  );

  // All-ones is the XNOR lock-up state; a match there proves nothing about sync.
  assign all_ones    = &shift_reg;
  assign locked_miss = Enable && (state == LOCKED) && (Din != predict);

  // Synchronisation FSM: fill, hunt for a clean run, then flywheel on the prediction while locked.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= FILL;
      shift_reg <= '0;
      fill_cnt  <= '0;
      run_cnt   <= '0;
      miss_cnt  <= '0;
      Locked    <= 1'b0;
      ErrPulse  <= 1'b0;
    end else begin
      ErrPulse <= 1'b0;
      if (Enable) begin
        case (state)
          FILL: begin
            shift_reg <= {shift_reg[LFSR_WIDTH-2:0], Din};
            if (fill_cnt == FILL_LAST) begin
              state    <= HUNT;
              fill_cnt <= '0;
              run_cnt  <= '0;
            end else begin
              fill_cnt <= fill_cnt + 4'd1;
            end
          end
          HUNT: begin
            shift_reg <= {shift_reg[LFSR_WIDTH-2:0], Din};
            if (all_ones || (Din != predict)) begin
              run_cnt <= '0;
            end else if (run_cnt == LOCK_LAST) begin
              state    <= LOCKED;
              Locked   <= 1'b1;
              run_cnt  <= '0;
              miss_cnt <= '0;
            end else begin
              run_cnt <= run_cnt + 8'd1;
            end
          end
          LOCKED: begin
            shift_reg <= {shift_reg[LFSR_WIDTH-2:0], predict};
            if (Din != predict) begin
              ErrPulse <= 1'b1;
              if (miss_cnt == LOST_LAST) begin
                state    <= FILL;
                fill_cnt <= '0;
                miss_cnt <= '0;
                Locked   <= 1'b0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state    <= FILL;
            fill_cnt <= '0;
            Locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counter; a clear coinciding with a miss keeps that miss.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ErrCount <= '0;
    end else if (ClrErr) begin
      ErrCount <= locked_miss ? ERR_W'(1) : '0;
    end else if (locked_miss && (ErrCount != {ERR_W{1'b1}})) begin
      ErrCount <= ErrCount + ERR_W'(1);
    end
  end

`ifdef LFSR_CHK_BITCNT_EN
  // Count of valid bits checked while locked, wrapping at 32 bits.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      BitCount <= '0;
    end else if (ClrErr) begin
      BitCount <= '0;
    end else if (Enable && (state == LOCKED)) begin
      BitCount <= BitCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr9_checker.sv
// tb_lfsr9_checker: directed bench for lfsr9_checker driven by a reference generator model.
`timescale 1ns/1ps
module tb_lfsr9_checker;

  logic        Clock;
  logic        Reset;
  logic        Enable;
  logic        Din;
  logic        ClrErr;
  logic        Locked;
  logic        ErrPulse;
  logic [15:0] ErrCount;
`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0] BitCount;
`endif

  int          checks;
  int          fails;
  logic [8:0]  gen;
  logic        pulse_seen;
  logic        lock_seen;
  logic        b;

  lfsr9_checker dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enable   (Enable),
    .Din      (Din),
    .ClrErr   (ClrErr),
    .Locked   (Locked),
    .ErrPulse (ErrPulse),
`ifdef LFSR_CHK_BITCNT_EN
    .BitCount (BitCount),
`endif
    .ErrCount (ErrCount)
  );

  // Free-running 10 ns clock.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        fails++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Reference generator: XNOR taps 4,8, newest bit in position 0.
  task automatic gen_bit(output logic nb);
    nb  = ~(gen[4] ^ gen[8]);
    gen = {gen[7:0], nb};
  endtask

  // Drive one cycle of inputs and settle just after the rising edge.
  task automatic apply_bit(input logic bit_in, input logic en, input logic clr);
    Din    = bit_in;
    Enable = en;
    ClrErr = clr;
    @(posedge Clock);
    #1;
    ClrErr = 1'b0;
    if (ErrPulse) pulse_seen = 1'b1;
    if (Locked)   lock_seen  = 1'b1;
  endtask

  task automatic send_clean(input int n);
    logic cb;
    repeat (n) begin
      gen_bit(cb);
      apply_bit(cb, 1'b1, 1'b0);
    end
  endtask

  initial begin
    checks     = 0;
    fails      = 0;
    gen        = '0;
    pulse_seen = 1'b0;
    lock_seen  = 1'b0;
    Reset      = 1'b0;
    Enable     = 1'b0;
    Din        = 1'b0;
    ClrErr     = 1'b0;

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check_output("reset_locked", 32'(Locked), 32'd0);
    check_output("reset_pulse",  32'(ErrPulse), 32'd0);
    check_output("reset_count",  32'(ErrCount), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // Clean lock: 9 fill bits plus 16 matches
    send_clean(24);
    check_output("lock_24", 32'(Locked), 32'd0);
    send_clean(1);
    check_output("lock_25", 32'(Locked), 32'd1);
    pulse_seen = 1'b0;
    send_clean(575);
    check_output("clean_locked", 32'(Locked), 32'd1);
    check_output("clean_count",  32'(ErrCount), 32'd0);
    check_output("clean_nopulse", 32'(pulse_seen), 32'd0);
`ifdef LFSR_CHK_BITCNT_EN
    check_output("clean_bitcount", BitCount, 32'd575);
`endif

    // Single flipped bit 100 bits after lock
    send_clean(99);
    gen_bit(b);
    apply_bit(~b, 1'b1, 1'b0);
    check_output("single_pulse",  32'(ErrPulse), 32'd1);
    check_output("single_count",  32'(ErrCount), 32'd1);
    check_output("single_locked", 32'(Locked), 32'd1);
    send_clean(1);
    check_output("single_pulse_end", 32'(ErrPulse), 32'd0);
    check_output("single_count_hold", 32'(ErrCount), 32'd1);

    // Clear alone on a clean bit
    gen_bit(b);
    apply_bit(b, 1'b1, 1'b1);
    check_output("clr_count", 32'(ErrCount), 32'd0);
    check_output("clr_pulse", 32'(ErrPulse), 32'd0);

    // Clear coinciding with a mismatch
    gen_bit(b);
    apply_bit(~b, 1'b1, 1'b1);
    check_output("clr_miss_count", 32'(ErrCount), 32'd1);
    check_output("clr_miss_pulse", 32'(ErrPulse), 32'd1);
    send_clean(1);

    // Mismatch followed by an idle cycle
    gen_bit(b);
    apply_bit(~b, 1'b1, 1'b0);
    check_output("idle_pre_pulse", 32'(ErrPulse), 32'd1);
    check_output("idle_pre_count", 32'(ErrCount), 32'd2);
    apply_bit(~gen[0], 1'b0, 1'b0);
    check_output("idle_pulse",  32'(ErrPulse), 32'd0);
    check_output("idle_count",  32'(ErrCount), 32'd2);
    check_output("idle_locked", 32'(Locked), 32'd1);
    send_clean(1);

    // Burst of four inverted bits drops lock, then relock
    gen_bit(b);
    apply_bit(b, 1'b1, 1'b1);
    check_output("burst_clr", 32'(ErrCount), 32'd0);
    for (int i = 0; i < 4; i++) begin
      gen_bit(b);
      apply_bit(~b, 1'b1, 1'b0);
      if (i == 2) begin
        check_output("burst3_locked", 32'(Locked), 32'd1);
        check_output("burst3_count",  32'(ErrCount), 32'd3);
      end
    end
    check_output("burst4_locked", 32'(Locked), 32'd0);
    check_output("burst4_count",  32'(ErrCount), 32'd4);
    check_output("burst4_pulse",  32'(ErrPulse), 32'd1);
    send_clean(24);
    check_output("relock_24", 32'(Locked), 32'd0);
    send_clean(1);
    check_output("relock_25", 32'(Locked), 32'd1);
    check_output("relock_count", 32'(ErrCount), 32'd4);

    // Asynchronous reset between edges
    #2;
    Reset = 1'b0;
    #1;
    check_output("areset_locked", 32'(Locked), 32'd0);
    check_output("areset_pulse",  32'(ErrPulse), 32'd0);
    check_output("areset_count",  32'(ErrCount), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // Enable toggling every other cycle: lock point counted in valid bits
    gen = '0;
    for (int k = 1; k <= 25; k++) begin
      gen_bit(b);
      apply_bit(b, 1'b1, 1'b0);
      if (k == 24) check_output("toggle_24", 32'(Locked), 32'd0);
      if (k == 25) check_output("toggle_25", 32'(Locked), 32'd1);
      apply_bit(~b, 1'b0, 1'b0);
    end
    check_output("toggle_count", 32'(ErrCount), 32'd0);

    // All-ones stream never locks
    Reset = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Reset     = 1'b1;
    lock_seen = 1'b0;
    repeat (100) apply_bit(1'b1, 1'b1, 1'b0);
    check_output("ones_nolock", 32'(lock_seen), 32'd0);
    check_output("ones_count",  32'(ErrCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
